// File: rtl/instr_split_queue_pkg.sv
// Shared constants for the instruction split queue and its decode stages:
// MIPS field bit positions, immediate-extension encodings and the R-type opcode.
package instr_split_queue_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int SH_MSB   = 10;
  localparam int SH_LSB   = 6;
  localparam int FN_MSB   = 5;
  localparam int FN_LSB   = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int JIDX_MSB = 25;
  localparam int JIDX_LSB = 0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'd0,
    EXT_SIGN  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_RSVD  = 2'd3
  } ext_mode_e;

  // The reserved encoding deliberately behaves like zero extension.
  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [1:0] mode);
    case (ext_mode_e'(mode))
      EXT_SIGN:           return {{16{imm[15]}}, imm};
      EXT_UPPER:          return {imm, 16'h0000};
      EXT_ZERO, EXT_RSVD: return {16'h0000, imm};
      default:            return {16'h0000, imm};
    endcase
  endfunction

endpackage

// File: rtl/instr_split_queue_field_decode.sv
// Pure combinational split of a MIPS instruction word into its fields,
// shared with later decode stages.
module instr_field_decode
  import instr_split_queue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [1:0]  ext_mode,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] imm32,
  output logic [25:0] jidx,
  output logic        is_rtype
);

  assign opcode   = instr[OPC_MSB:OPC_LSB];
  assign rs       = instr[RS_MSB:RS_LSB];
  assign rt       = instr[RT_MSB:RT_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign shamt    = instr[SH_MSB:SH_LSB];
  assign funct    = instr[FN_MSB:FN_LSB];
  assign imm16    = instr[IMM_MSB:IMM_LSB];
  assign jidx     = instr[JIDX_MSB:JIDX_LSB];
  assign imm32    = extend_imm(imm16, ext_mode);
  assign is_rtype = (opcode == OPC_RTYPE);

endmodule

// File: rtl/instr_split_queue.sv
// Circular instruction queue of {pc, instr} entries whose head is decoded into
// MIPS fields combinationally; flush drops everything on the next edge.
module instr_split_queue
  import instr_split_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic [1:0]               ext_mode,
  output logic [PC_W-1:0]          out_pc,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              imm16,
  output logic [31:0]              imm32,
  output logic [25:0]              jidx,
  output logic                     is_rtype,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PC_W-1:0]  pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];

  logic push;
  logic pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  // Pointers are exactly PTR_W bits wide, so DEPTH-1 + 1 wraps to 0 on its own.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  logic [5:0]  dec_opcode;
  logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shamt;
  logic [5:0]  dec_funct;
  logic [15:0] dec_imm16;
  logic [31:0] dec_imm32;
  logic [25:0] dec_jidx;
  logic        dec_is_rtype;

  instr_field_decode u_decode (
    .instr    (instr_mem_q[rd_ptr_q]),
    .ext_mode (ext_mode),
    .opcode   (dec_opcode),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .rd       (dec_rd),
    .shamt    (dec_shamt),
    .funct    (dec_funct),
    .imm16    (dec_imm16),
    .imm32    (dec_imm32),
    .jidx     (dec_jidx),
    .is_rtype (dec_is_rtype)
  );

  // An empty queue presents all-zero fields, including is_rtype.
  always_comb begin
    out_pc   = '0;
    opcode   = '0;
    rs       = '0;
    rt       = '0;
    rd       = '0;
    shamt    = '0;
    funct    = '0;
    imm16    = '0;
    imm32    = '0;
    jidx     = '0;
    is_rtype = 1'b0;
    if (out_valid) begin
      out_pc   = pc_mem_q[rd_ptr_q];
      opcode   = dec_opcode;
      rs       = dec_rs;
      rt       = dec_rt;
      rd       = dec_rd;
      shamt    = dec_shamt;
      funct    = dec_funct;
      imm16    = dec_imm16;
      imm32    = dec_imm32;
      jidx     = dec_jidx;
      is_rtype = dec_is_rtype;
    end
  end

endmodule

// File: tb/tb_instr_split_queue.sv
// Self-checking bench: directed cases with literal expectations, then random
// traffic compared every cycle against a queue-based reference model.
module tb_instr_split_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [31:0]       in_instr = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        ext_mode = 2'd0;
  logic [PC_W-1:0]   out_pc;
  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [31:0]       imm32;
  logic [25:0]       jidx;
  logic              is_rtype;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  instr_split_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .ext_mode  (ext_mode),
    .out_pc    (out_pc),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm16     (imm16),
    .imm32     (imm32),
    .jidx      (jidx),
    .is_rtype  (is_rtype),
    .count     (count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the model queue with plain arithmetic.
  task automatic compare_all();
    int          n;
    logic [31:0] h;
    logic [31:0] p;
    logic [31:0] imm;
    logic [31:0] ext;
    n = q.size();
    h = (n > 0) ? q[0].instr : 32'd0;
    p = (n > 0) ? q[0].pc    : 32'd0;
    imm = h & 32'hFFFF;
    case (ext_mode)
      2'd1:    ext = (imm >= 32'h8000) ? (imm + 32'hFFFF0000) : imm;
      2'd2:    ext = imm * 32'h10000;
      default: ext = imm;
    endcase
    check("count",     64'(count),     64'(n));
    check("in_ready",  64'(in_ready),  64'(n != DEPTH));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("out_pc",    64'(out_pc),    64'(p));
    check("opcode",    64'(opcode),    64'(h / 32'h400_0000));
    check("rs",        64'(rs),        64'((h / 32'h20_0000) % 32));
    check("rt",        64'(rt),        64'((h / 32'h1_0000) % 32));
    check("rd",        64'(rd),        64'((h / 32'h800) % 32));
    check("shamt",     64'(shamt),     64'((h / 32'h40) % 32));
    check("funct",     64'(funct),     64'(h % 64));
    check("imm16",     64'(imm16),     64'(imm));
    check("imm32",     64'(imm32),     64'(ext));
    check("jidx",      64'(jidx),      64'(h % 32'h400_0000));
    check("is_rtype",  64'(is_rtype),  64'((n != 0) && (h < 32'h400_0000)));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
  endtask

  // One clock: decide model acceptance from pre-edge state, update, compare.
  task automatic cycle();
    bit   can_push;
    bit   can_pop;
    ent_t e;
    can_push = (q.size() < DEPTH);
    can_pop  = (q.size() > 0);
    e.pc     = in_pc;
    e.instr  = in_instr;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready && can_pop) void'(q.pop_front());
      if (in_valid && can_push) q.push_back(e);
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_is_rtype",  64'(is_rtype),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    compare_all();

    // R-type push into empty queue: visible after exactly one edge.
    drive(1, 32'h100, 32'h012A4020, 0, 0);
    cycle();
    check("r_valid", 64'(out_valid), 64'd1);
    check("r_rtype", 64'(is_rtype),  64'd1);
    check("r_rs",    64'(rs),        64'd9);
    check("r_rt",    64'(rt),        64'd10);
    check("r_rd",    64'(rd),        64'd8);
    check("r_shamt", 64'(shamt),     64'd0);
    check("r_funct", 64'(funct),     64'h20);
    check("r_pc",    64'(out_pc),    64'h100);

    drive(0, 0, 0, 1, 0);
    cycle();
    check("r_popped", 64'(out_valid), 64'd0);

    // I-type immediate extension under every ext_mode.
    drive(1, 32'h104, 32'h2128FFFF, 0, 0);
    cycle();
    check("i_opcode", 64'(opcode), 64'h08);
    check("i_rs",     64'(rs),     64'd9);
    check("i_rt",     64'(rt),     64'd8);
    ext_mode = 2'd0; #1 check("i_ext0", 64'(imm32), 64'h0000FFFF);
    ext_mode = 2'd1; #1 check("i_ext1", 64'(imm32), 64'hFFFFFFFF);
    ext_mode = 2'd2; #1 check("i_ext2", 64'(imm32), 64'hFFFF0000);
    ext_mode = 2'd3; #1 check("i_ext3", 64'(imm32), 64'h0000FFFF);
    ext_mode = 2'd0;

    // Simultaneous push and pop keeps count at 1 and replaces the head.
    drive(1, 32'h108, 32'h08100004, 1, 0);
    cycle();
    check("j_count",  64'(count),    64'd1);
    check("j_opcode", 64'(opcode),   64'h02);
    check("j_jidx",   64'(jidx),     64'h0100004);
    check("j_rtype",  64'(is_rtype), 64'd0);
    drive(0, 0, 0, 1, 0);
    cycle();

    // Fill across the pointer wrap, overfill, and pop-with-push while full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h200 + 32'(i * 4), 32'h2000_0000 + 32'(i), 0, 0);
      cycle();
    end
    check("full_count", 64'(count),    64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    drive(1, 32'h2F0, 32'hDEAD_BEEF, 0, 0);
    cycle();
    check("ovf_count", 64'(count),  64'd4);
    check("ovf_pc",    64'(out_pc), 64'h200);
    drive(1, 32'h2F4, 32'h2000_0004, 1, 0);
    cycle();
    check("fullpop_count", 64'(count),  64'd3);
    check("fullpop_pc",    64'(out_pc), 64'h204);
    drive(1, 32'h2F8, 32'h2000_0005, 0, 0);
    cycle();
    check("refill_count", 64'(count), 64'd4);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 1, 0);
      cycle();
    end
    check("drained", 64'(count), 64'd0);

    // Flush overrides same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i * 4), 32'h0000_0020 + 32'(i), 0, 0);
      cycle();
    end
    drive(1, 32'h3F0, 32'h1111_1111, 1, 1);
    cycle();
    check("flush_count", 64'(count),     64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 0, 0);
    cycle();
    check("flush_lost", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges with two entries held.
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h400 + 32'(i * 4), 32'h3C01_0000 + 32'(i), 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid",  64'(out_valid), 64'd0);
    check("arst_count",  64'(count),     64'd0);
    check("arst_ready",  64'(in_ready),  64'd1);
    check("arst_opcode", 64'(opcode),    64'd0);
    check("arst_pc",     64'(out_pc),    64'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compare_all();

    // Random traffic with phase-varying bias to visit full and empty often.
    for (int i = 0; i < 2000; i++) begin
      int bias;
      bias = (i / 200) % 3;
      in_valid  = ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2)));
      out_ready = ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2)));
      flush     = ($urandom_range(0, 31) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      ext_mode  = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_split_queue.md
INSTR_SPLIT_QUEUE -- requirements
Module: instr_split_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries buffered (power of two, >= 2).
REQ-002 Parameter PC_W, default 32, width of the program-counter tag stored with each instruction.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; clk and reset are listed first below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  producer offers {in_pc, in_instr} this cycle.
REQ-007 in_ready  output  1  queue can accept an entry this cycle.
REQ-008 in_pc  input  PC_W  PC of offered instruction.
REQ-009 in_instr  input  32  offered MIPS instruction word.
REQ-010 out_valid  output  1  head entry present and fields valid.
REQ-011 out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 flush  input  1  synchronous discard of all entries (branch redirect).
REQ-013 ext_mode  input  2  immediate extension select: 0 zero, 1 sign, 2 upper (lui), 3 reserved (zero).
REQ-014 out_pc  output  PC_W  head PC.
REQ-015 opcode/rs/rt/rd/shamt/funct  output  6/5/5/5/5/6  head fields [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0].
REQ-016 imm16  output  16  head [15:0]; imm32  output  32  extended per ext_mode.
REQ-017 jidx  output  26  head [25:0]; is_rtype  output  1  opcode == 6'h00.
REQ-018 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Storage SHALL be a circular buffer of DEPTH entries {pc, instr} with wrapping write and read pointers.
REQ-020 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0).
REQ-021 Push occurs on a rising edge when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 When full, in_ready is 0 regardless of out_ready; a same-cycle pop does not enable a push.
REQ-024 No bypass: an entry pushed into an empty queue appears at the head (out_valid=1) the next cycle; latency 1 cycle.
REQ-025 All field outputs SHALL be combinational decodes of the head entry; when out_valid=0 they SHALL be driven to 0.
REQ-026 imm32: mode 0 {16'h0,imm16}; mode 1 {{16{imm16[15]}},imm16}; mode 2 {imm16,16'h0}; mode 3 as mode 0.
REQ-027 flush SHALL set both pointers and count to 0 on the next edge and overrides a same-cycle push and pop.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; entry order SHALL be strictly FIFO.
REQ-029 Inputs offered while in_ready=0 SHALL be ignored with no state change.

Reset
REQ-030 reset SHALL immediately clear pointers and count, forcing out_valid=0, in_ready=1, all field outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard every entry; storage contents need not be cleared.

Structure
REQ-032 A shared package SHALL hold field bit-position constants, ext_mode encodings, and OPC_RTYPE=6'h00.
REQ-033 The field decode SHALL be a sub-module instr_field_decode (instruction + ext_mode in, all field outputs out), reused by later decode stages.

Verification
REQ-034 Push 0x012A4020 into empty queue -> next cycle out_valid=1, is_rtype=1, rs=9, rt=10, rd=8, shamt=0, funct=0x20.
REQ-035 Head 0x2128FFFF -> opcode=0x08, rs=9, rt=8; ext_mode 0/1/2 gives imm32 0x0000FFFF/0xFFFFFFFF/0xFFFF0000.
REQ-036 Head 0x08100004 -> opcode=0x02, jidx=0x0100004, is_rtype=0.
REQ-037 DEPTH=4: push 4 without pop -> count=4, in_ready=0; 5th offer ignored; pop with push offered -> count=3, then push accepted; pop order equals push order across pointer wrap.
REQ-038 Queue holding 3 entries, flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, offered entry lost.
REQ-039 Reset pulse asserted between clock edges with 2 entries -> out_valid=0 and count=0 immediately, before next edge.
